hilo_seq_unit: RTL and testbench

//  Multicycle sequencer and HI/LO register pair placed after the MULT/DIV datapaths.
//  - Accepts MULT/DIV start pulses from control.
//  - Latches operands and drives them to the iterative units.
//  - Counts their fixed latency, then captures the 64-bit result into HI/LO.
//  - Serves MFHI/MFLO reads and MTHI/MTLO writes; busy is the stall source for the control FSM.

---
 rtl/hilo_seq_unit.sv | 138 +++++++++++++
 tb/tb_hilo_seq_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_seq_unit.sv
`default_nettype none
// ============================================================================
// hilo_seq_unit : MULT/DIV sequencer with HI/LO register pair
// Rev 1.0
// ============================================================================
module hilo_seq_unit #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_start,
  input  logic        div_start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        hi_write,
  input  logic        lo_write,
  input  logic [31:0] wr_data,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] count, count_nx;
  logic [31:0]   op_a_reg, op_a_nx;
  logic [31:0]   op_b_reg, op_b_nx;
  logic [31:0]   hi_reg, hi_nx;
  logic [31:0]   lo_reg, lo_nx;
  logic          done_reg, done_nx;
  logic          dz_reg, dz_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      op_a_reg <= '0;
      op_b_reg <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      done_reg <= 1'b0;
      dz_reg   <= 1'b0;
    end else begin
      state    <= state_nx;
      count    <= count_nx;
      op_a_reg <= op_a_nx;
      op_b_reg <= op_b_nx;
      hi_reg   <= hi_nx;
      lo_reg   <= lo_nx;
      done_reg <= done_nx;
      dz_reg   <= dz_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    op_a_nx  = op_a_reg;
    op_b_nx  = op_b_reg;
    hi_nx    = hi_reg;
    lo_nx    = lo_reg;
    done_nx  = 1'b0;
    dz_nx    = 1'b0;

    unique case (state)
      IDLE: begin
        // Register writes and a start may coincide; the result overwrites later.
        if (hi_write) hi_nx = wr_data;
        if (lo_write) lo_nx = wr_data;
        if (mult_start) begin
          op_a_nx  = a_in;
          op_b_nx  = b_in;
          count_nx = MULT_LOAD;
          state_nx = MULT;
        end else if (div_start) begin
          if (b_in != '0) begin
            op_a_nx  = a_in;
            op_b_nx  = b_in;
            count_nx = DIV_LOAD;
            state_nx = DIV;
          end else begin
            dz_nx = 1'b1;
          end
        end
      end
      MULT: begin
        if (count == '0) begin
          hi_nx    = mult_hi;
          lo_nx    = mult_lo;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          count_nx = count - CW'(1);
        end
      end
      DIV: begin
        if (count == '0) begin
          hi_nx    = div_hi;
          lo_nx    = div_lo;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          count_nx = count - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign op_a     = op_a_reg;
  assign op_b     = op_b_reg;
  assign hi_out   = hi_reg;
  assign lo_out   = lo_reg;
  assign busy     = (state != IDLE);
  assign done     = done_reg;
  assign div_zero = dz_reg;

endmodule
`default_nettype wire

// File: tb/tb_hilo_seq_unit.sv
`default_nettype none
// Self-checking bench for hilo_seq_unit with behavioural mult/div datapaths.
module tb_hilo_seq_unit;

  localparam int N_MULT = 32;
  localparam int N_DIV  = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        mult_start, div_start;
  logic [31:0] a_in, b_in;
  logic [31:0] op_a, op_b;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
  logic        hi_write, lo_write;
  logic [31:0] wr_data;
  logic [31:0] hi_out, lo_out;
  logic        busy, done, div_zero;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_hi, model_lo;

  hilo_seq_unit #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
    .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
    .a_in(a_in), .b_in(b_in), .op_a(op_a), .op_b(op_b),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
    .hi_write(hi_write), .lo_write(lo_write), .wr_data(wr_data),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier and divider fed from the latched operands.
  always_comb begin
    longint p;
    int sa, sb;
    p  = longint'($signed(op_a)) * longint'($signed(op_b));
    mult_hi = p[63:32];
    mult_lo = p[31:0];
    sa = $signed(op_a);
    sb = $signed(op_b);
    if (sb == 0 || (sa == 32'h8000_0000 && sb == -1)) begin
      div_hi = '0;
      div_lo = '0;
    end else begin
      div_hi = 32'(sa % sb);
      div_lo = 32'(sa / sb);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mult_start = 1'b0;
    div_start  = 1'b0;
    hi_write   = 1'b0;
    lo_write   = 1'b0;
  endtask

  // One full operation: start cycle, N busy cycles, capture, done pulse.
  task automatic run_op(input bit is_div, input bit both, input bit wr,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] wdata, input string tag);
    logic [63:0] expv;
    int n;
    longint prod;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (is_div) begin
      expv = {32'(sa % sb), 32'(sa / sb)};
      n = N_DIV;
    end else begin
      prod = longint'(sa) * longint'(sb);
      expv = prod;
      n = N_MULT;
    end
    mult_start = !is_div || both;
    div_start  = is_div || both;
    a_in = a;
    b_in = b;
    hi_write = wr;
    lo_write = wr;
    wr_data  = wdata;
    tick();
    idle_inputs();
    a_in = $urandom;
    b_in = $urandom;
    if (wr) begin
      model_hi = wdata;
      model_lo = wdata;
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || div_zero !== 1'b0 ||
          hi_out !== model_hi || lo_out !== model_lo || op_a !== a || op_b !== b) begin
        errors++;
        $display("FAIL %s busy-phase cyc%0d: busy=%b done=%b dz=%b hi=%h lo=%h opa=%h opb=%h, want busy=1 done=0 dz=0 hi=%h lo=%h opa=%h opb=%h",
                 tag, k, busy, done, div_zero, hi_out, lo_out, op_a, op_b, model_hi, model_lo, a, b);
      end
      tick();
    end
    model_hi = expv[63:32];
    model_lo = expv[31:0];
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || hi_out !== model_hi || lo_out !== model_lo) begin
      errors++;
      $display("FAIL %s capture: busy=%b done=%b hi=%h lo=%h, want busy=0 done=1 hi=%h lo=%h",
               tag, busy, done, hi_out, lo_out, model_hi, model_lo);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || hi_out !== model_hi || lo_out !== model_lo) begin
      errors++;
      $display("FAIL %s after-done: done=%b busy=%b hi=%h lo=%h, want done=0 busy=0 hi=%h lo=%h",
               tag, done, busy, hi_out, lo_out, model_hi, model_lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    a_in = $urandom;
    b_in = $urandom;
    wr_data = '0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0 || hi_out !== '0 ||
        lo_out !== '0 || op_a !== '0 || op_b !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b dz=%b hi=%h lo=%h opa=%h opb=%h, want all 0",
               busy, done, div_zero, hi_out, lo_out, op_a, op_b);
    end
    reset = 1'b0;
    model_hi = '0;
    model_lo = '0;
  endtask

  task automatic test_mult();
    logic [31:0] a, b;
    run_op(1'b0, 1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD, '0, "mult_7x-3");
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom;
      run_op(1'b0, 1'b0, 1'b0, a, b, '0, "mult_rand");
    end
  endtask

  task automatic test_div();
    logic [31:0] a, b;
    run_op(1'b1, 1'b0, 1'b0, 32'd100, 32'd7, '0, "div_100/7");
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom_range(1, 2000);
      if (i[0]) b = -b;
      run_op(1'b1, 1'b0, 1'b0, a, b, '0, "div_rand");
    end
  endtask

  task automatic test_div_zero();
    hi_write = 1'b1; wr_data = 32'd5;
    tick();
    hi_write = 1'b0; lo_write = 1'b1; wr_data = 32'd6;
    tick();
    lo_write = 1'b0;
    model_hi = 32'd5;
    model_lo = 32'd6;
    div_start = 1'b1; a_in = 32'd77; b_in = 32'd0;
    tick();
    div_start = 1'b0;
    checks++;
    if (div_zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || hi_out !== 32'd5 || lo_out !== 32'd6) begin
      errors++;
      $display("FAIL div_zero pulse: dz=%b busy=%b done=%b hi=%h lo=%h, want dz=1 busy=0 done=0 hi=5 lo=6",
               div_zero, busy, done, hi_out, lo_out);
    end
    tick();
    checks++;
    if (div_zero !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || hi_out !== 32'd5 || lo_out !== 32'd6) begin
      errors++;
      $display("FAIL div_zero after: dz=%b busy=%b done=%b hi=%h lo=%h, want dz=0 busy=0 done=0 hi=5 lo=6",
               div_zero, busy, done, hi_out, lo_out);
    end
  endtask

  task automatic test_priority();
    // Divide 1000 / -13 with a mult_start and an MTHI injected mid-flight.
    div_start = 1'b1; a_in = 32'd1000; b_in = -32'sd13;
    tick();
    div_start = 1'b0;
    for (int k = 0; k < N_DIV; k++) begin
      mult_start = (k == 10);
      if (k == 10) begin a_in = 32'd5; b_in = 32'd9; end
      hi_write = (k == 11);
      lo_write = (k == 11);
      wr_data  = 32'hDEAD_BEEF;
      checks++;
      if (busy !== 1'b1 || op_a !== 32'd1000 || op_b !== 32'hFFFF_FFF3 ||
          hi_out !== model_hi || lo_out !== model_lo || done !== 1'b0) begin
        errors++;
        $display("FAIL ignore-while-busy cyc%0d: busy=%b opa=%h opb=%h hi=%h lo=%h done=%b, want busy=1 opa=000003e8 opb=fffffff3 hi=%h lo=%h done=0",
                 k, busy, op_a, op_b, hi_out, lo_out, done, model_hi, model_lo);
      end
      tick();
    end
    idle_inputs();
    model_hi = 32'd12;
    model_lo = -32'sd76;
    checks++;
    if (done !== 1'b1 || hi_out !== model_hi || lo_out !== model_lo) begin
      errors++;
      $display("FAIL div_after_ignore: done=%b hi=%h lo=%h, want done=1 hi=%h lo=%h",
               done, hi_out, lo_out, model_hi, model_lo);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_mult_started: busy=%b, want 0", busy);
    end
    // Simultaneous starts with b=0: multiply must run, no div_zero.
    run_op(1'b0, 1'b1, 1'b0, -32'sd6, 32'd0, '0, "both_starts_b0");
    run_op(1'b0, 1'b1, 1'b0, 32'd1234, 32'd5678, '0, "both_starts");
  endtask

  task automatic test_reset_mid();
    mult_start = 1'b1; a_in = 32'd123; b_in = 32'd456;
    tick();
    mult_start = 1'b0;
    for (int k = 0; k < 14; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_hi = '0;
    model_lo = '0;
    checks++;
    if (busy !== 1'b0 || hi_out !== '0 || lo_out !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b hi=%h lo=%h done=%b, want busy=0 hi=0 lo=0 done=0",
               busy, hi_out, lo_out, done);
    end
    for (int k = 0; k < 24; k++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || hi_out !== '0 || lo_out !== '0) begin
        errors++;
        $display("FAIL reset_mid_quiet cyc%0d: done=%b busy=%b hi=%h lo=%h, want 0",
                 k, done, busy, hi_out, lo_out);
      end
      tick();
    end
    run_op(1'b0, 1'b0, 1'b0, 32'd123, 32'd456, '0, "mult_after_reset");
  endtask

  task automatic test_idle_write();
    hi_write = 1'b1; lo_write = 1'b1; wr_data = 32'h1234_5678;
    tick();
    idle_inputs();
    model_hi = 32'h1234_5678;
    model_lo = 32'h1234_5678;
    checks++;
    if (hi_out !== model_hi || lo_out !== model_lo || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_write: hi=%h lo=%h busy=%b, want hi=lo=12345678 busy=0",
               hi_out, lo_out, busy);
    end
    lo_write = 1'b1; wr_data = 32'hCAFE_0001;
    tick();
    idle_inputs();
    model_lo = 32'hCAFE_0001;
    checks++;
    if (hi_out !== model_hi || lo_out !== model_lo) begin
      errors++;
      $display("FAIL lo_only_write: hi=%h lo=%h, want hi=%h lo=%h",
               hi_out, lo_out, model_hi, model_lo);
    end
  endtask

  task automatic test_back_to_back();
    run_op(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hAAAA_5555, "write_and_mult");
    run_op(1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'd3, 32'h0F0F_0F0F, "write_and_div");
    run_op(1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, '0, "mult_minmin");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_priority();
    test_reset_mid();
    test_idle_write();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
